// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
// Write-back queue between the pipeline result mux and the register file.
// Results arrive through a valid/ready handshake. They are buffered in an
// in-order FIFO and drained one per cycle onto the register file write port.
// Two combinational bypass lookups let operand readers see results that
// have not yet been written.
//
// Optional feature: define WBQ_COALESCE_EN to merge a new write into the
// youngest pending entry for the same register instead of allocating.
//
// Ports:
//   PCclk              clock, all state updates on the rising edge
//   rst                synchronous active-high reset
//   in_valid/in_ready  producer handshake
//   in_reg/in_dat      destination register index and result data
//   wr_stall           register file write port busy, holds the drain
//   regW/Wdat/RegWrite registered register file write port
//   regA/regB          bypass lookup indices
//   Afwd/Bfwd          bypassed data for regA/regB
//   Ahit/Bhit          a pending value exists for regA/regB
//   count              number of occupied queue entries, 0..DEPTH
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             PCclk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_reg,
  input  logic [31:0]      in_dat,
  input  logic             wr_stall,
  output logic [4:0]       regW,
  output logic [31:0]      Wdat,
  output logic             RegWrite,
  input  logic [4:0]       regA,
  input  logic [4:0]       regB,
  output logic [31:0]      Afwd,
  output logic [31:0]      Bfwd,
  output logic             Ahit,
  output logic             Bhit,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [4:0]       q_reg [DEPTH];
  logic [31:0]      q_dat [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic [PTR_W-1:0] slot [DEPTH];
  logic [DEPTH-1:0] slot_valid;

  logic             pop;
  logic             push;
  logic             alloc;
  logic             coal;
  logic [PTR_W-1:0] coal_slot;

  logic             qa_hit;
  logic             qb_hit;
  logic [31:0]      qa_dat;
  logic [31:0]      qb_dat;

  // A full queue never accepts, even when the head drains in the same cycle.
  // Writes to register 0 complete the handshake but are dropped.
  assign in_ready = !rst && (count != FULL);
  assign pop      = (count != '0) && !wr_stall;
  assign push     = in_valid && in_ready && (in_reg != 5'd0);
  assign alloc    = push && !coal;

  // Map age order (0 = head, oldest) to physical slots so that searches
  // can walk from oldest to youngest regardless of pointer wrap.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      slot[k]       = head + PTR_W'(k);
      slot_valid[k] = ((PTR_W+1)'(k) < count);
    end
  end

  // Queue search for both bypass ports. Later (younger) matches override
  // earlier ones, so the youngest pending value wins.
  always_comb begin
    qa_hit = 1'b0;
    qb_hit = 1'b0;
    qa_dat = '0;
    qb_dat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (slot_valid[k] && (q_reg[slot[k]] == regA)) begin
        qa_hit = 1'b1;
        qa_dat = q_dat[slot[k]];
      end
      if (slot_valid[k] && (q_reg[slot[k]] == regB)) begin
        qb_hit = 1'b1;
        qb_dat = q_dat[slot[k]];
      end
    end
  end

  // Bypass priority: pending queue entry first, then the value sitting on
  // the write port this cycle. Register 0 never forwards.
  always_comb begin
    Ahit = 1'b0;
    Afwd = '0;
    Bhit = 1'b0;
    Bfwd = '0;
    if (!rst && (regA != 5'd0)) begin
      if (qa_hit) begin
        Ahit = 1'b1;
        Afwd = qa_dat;
      end else if (RegWrite && (regW == regA)) begin
        Ahit = 1'b1;
        Afwd = Wdat;
      end
    end
    if (!rst && (regB != 5'd0)) begin
      if (qb_hit) begin
        Bhit = 1'b1;
        Bfwd = qb_dat;
      end else if (RegWrite && (regW == regB)) begin
        Bhit = 1'b1;
        Bfwd = Wdat;
      end
    end
  end

`ifdef WBQ_COALESCE_EN
  logic m_hit;
  logic m_is_head;

  // Find the youngest pending entry for the incoming register. A match on
  // the head is only usable when the head is not leaving this cycle.
  always_comb begin
    m_hit     = 1'b0;
    m_is_head = 1'b0;
    coal_slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (slot_valid[k] && (q_reg[slot[k]] == in_reg)) begin
        m_hit     = 1'b1;
        m_is_head = (k == 0);
        coal_slot = slot[k];
      end
    end
  end

  assign coal = push && m_hit && !(pop && m_is_head);
`else
  assign coal      = 1'b0;
  assign coal_slot = '0;
`endif

  // Queue storage carries no reset; only entries inside count are ever read.
  always_ff @(posedge PCclk) begin
    if (!rst) begin
      if (alloc) begin
        q_reg[tail] <= in_reg;
        q_dat[tail] <= in_dat;
      end else if (coal) begin
        q_dat[coal_slot] <= in_dat;
      end
    end
  end

  // Pointers, occupancy and the registered write port. The write port
  // loads the head on every pop; otherwise the enable drops and the index
  // and data hold.
  always_ff @(posedge PCclk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      RegWrite <= 1'b0;
      regW     <= '0;
      Wdat     <= '0;
    end else begin
      if (pop) begin
        head     <= head + 1'b1;
        regW     <= q_reg[head];
        Wdat     <= q_dat[head];
        RegWrite <= 1'b1;
      end else begin
        RegWrite <= 1'b0;
      end
      if (alloc) begin
        tail <= tail + 1'b1;
      end
      case ({alloc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue
// Self-checking bench for regfile_wb_queue: a directed vector table, a few
// hand-written multi-cycle sequences, and a randomized run compared
// against a queue-based reference model.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic           PCclk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [4:0]     in_reg;
  logic [31:0]    in_dat;
  logic           wr_stall;
  logic [4:0]     regW;
  logic [31:0]    Wdat;
  logic           RegWrite;
  logic [4:0]     regA;
  logic [4:0]     regB;
  logic [31:0]    Afwd;
  logic [31:0]    Bfwd;
  logic           Ahit;
  logic           Bhit;
  logic [PTR_W:0] count;

  int total = 0;
  int bad   = 0;

  // Free-running clock
  always #5 PCclk = ~PCclk;

  regfile_wb_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .PCclk    (PCclk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_reg   (in_reg),
    .in_dat   (in_dat),
    .wr_stall (wr_stall),
    .regW     (regW),
    .Wdat     (Wdat),
    .RegWrite (RegWrite),
    .regA     (regA),
    .regB     (regB),
    .Afwd     (Afwd),
    .Bfwd     (Bfwd),
    .Ahit     (Ahit),
    .Bhit     (Bhit),
    .count    (count)
  );

  // Reference model: a plain queue of pending writes plus the write port
  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_rw;
  logic [4:0]  m_regw;
  logic [31:0] m_wdat;

  function automatic void model_reset();
    mq.delete();
    m_rw   = 1'b0;
    m_regw = '0;
    m_wdat = '0;
  endfunction

  // One clock edge worth of behaviour, from the pre-edge inputs
  function automatic void model_step(input logic v, input logic [4:0] r,
                                     input logic [31:0] d, input logic s);
    bit   rdy;
    bit   pop;
    bit   push;
    ent_t e;
`ifdef WBQ_COALESCE_EN
    bit   merged;
`endif
    rdy  = (mq.size() != DEPTH);
    pop  = (mq.size() != 0) && !s;
    push = v && rdy && (r != 5'd0);
    if (pop) begin
      e      = mq.pop_front();
      m_rw   = 1'b1;
      m_regw = e.r;
      m_wdat = e.d;
    end else begin
      m_rw = 1'b0;
    end
    if (push) begin
`ifdef WBQ_COALESCE_EN
      merged = 1'b0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!merged && mq[i].r == r) begin
          mq[i].d = d;
          merged  = 1'b1;
        end
      end
      if (!merged) mq.push_back(ent_t'({r, d}));
`else
      mq.push_back(ent_t'({r, d}));
`endif
    end
  endfunction

  // Youngest pending value, else the write port, else nothing
  function automatic void model_lookup(input logic [4:0] idx, output logic hit,
                                       output logic [31:0] dat);
    hit = 1'b0;
    dat = '0;
    if (!rst && idx != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!hit && mq[i].r == idx) begin
          hit = 1'b1;
          dat = mq[i].d;
        end
      end
      if (!hit && m_rw && m_regw == idx) begin
        hit = 1'b1;
        dat = m_wdat;
      end
    end
  endfunction

  // Single comparison with failure reporting
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after the falling edge and let them settle
  task automatic applyStimulus(input logic r_st, input logic v,
                               input logic [4:0] r, input logic [31:0] d,
                               input logic s, input logic [4:0] ra,
                               input logic [4:0] rb);
    rst      = r_st;
    in_valid = v;
    in_reg   = r;
    in_dat   = d;
    wr_stall = s;
    regA     = ra;
    regB     = rb;
    #1;
  endtask

  // Compare every output against the model state
  task automatic modelCheck(input string tag);
    logic        eh;
    logic [31:0] ed;
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(!rst && mq.size() != DEPTH));
    checkOutput({tag, ".count"}, 32'(count), 32'(mq.size()));
    checkOutput({tag, ".RegWrite"}, 32'(RegWrite), 32'(m_rw));
    checkOutput({tag, ".regW"}, 32'(regW), 32'(m_regw));
    checkOutput({tag, ".Wdat"}, Wdat, m_wdat);
    model_lookup(regA, eh, ed);
    checkOutput({tag, ".Ahit"}, 32'(Ahit), 32'(eh));
    checkOutput({tag, ".Afwd"}, Afwd, ed);
    model_lookup(regB, eh, ed);
    checkOutput({tag, ".Bhit"}, 32'(Bhit), 32'(eh));
    checkOutput({tag, ".Bfwd"}, Bfwd, ed);
  endtask

  // Move the model and the DUT across one rising edge
  task automatic advance();
    if (rst) model_reset();
    else model_step(in_valid, in_reg, in_dat, wr_stall);
    @(posedge PCclk);
    @(negedge PCclk);
  endtask

  typedef struct {
    logic        v;
    logic [4:0]  r;
    logic [31:0] d;
    logic        s;
    logic [4:0]  ra;
    logic        e_rdy;
    int          e_cnt;
    logic        e_rw;
    logic [4:0]  e_regw;
    logic [31:0] e_wdat;
    logic        e_hit;
    logic [31:0] e_fwd;
  } vec_t;

  vec_t        vecs[17];
  logic [31:0] sb[$];
  int          nwr;

  // Main test sequence
  initial begin
    // Directed table: inputs, then outputs seen before that row's edge
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 1'b1, 0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b1, 1, 1'b0, 5'd0, 32'h0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b1, 0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd5, 1'b1, 0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 5'd2, 32'h22, 1'b1, 5'd1, 1'b1, 1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 32'h11};
    vecs[5]  = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd2, 1'b1, 2, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 32'h22};
    vecs[6]  = '{1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 1'b1, 3, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 32'h33};
    vecs[7]  = '{1'b1, 5'd9, 32'h99, 1'b1, 5'd4, 1'b0, 4, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 32'h44};
    vecs[8]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 4, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 1'b0, 4, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 32'h11};
    vecs[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 1'b1, 3, 1'b1, 5'd1, 32'h11, 1'b1, 32'h11};
    vecs[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd2, 1'b1, 2, 1'b1, 5'd2, 32'h22, 1'b1, 32'h22};
    vecs[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 1, 1'b1, 5'd3, 32'h33, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 1'b1, 0, 1'b1, 5'd4, 32'h44, 1'b1, 32'h44};
    vecs[14] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 1'b1, 0, 1'b0, 5'd4, 32'h44, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b1, 0, 1'b0, 5'd4, 32'h44, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 0, 1'b0, 5'd4, 32'h44, 1'b0, 32'h0};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_reg   = '0;
    in_dat   = '0;
    wr_stall = 1'b0;
    regA     = '0;
    regB     = '0;
    model_reset();
    @(negedge PCclk);

    // Initial reset: register outputs are unknown before the first edge
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd5);
    checkOutput("rst.in_ready", 32'(in_ready), 32'h0);
    checkOutput("rst.Ahit", 32'(Ahit), 32'h0);
    advance();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    advance();

    $display("[TB] directed vector table");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].s, vecs[i].ra, vecs[i].ra);
      checkOutput($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      checkOutput($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].e_cnt));
      checkOutput($sformatf("vec%0d.RegWrite", i), 32'(RegWrite), 32'(vecs[i].e_rw));
      checkOutput($sformatf("vec%0d.regW", i), 32'(regW), 32'(vecs[i].e_regw));
      checkOutput($sformatf("vec%0d.Wdat", i), Wdat, vecs[i].e_wdat);
      checkOutput($sformatf("vec%0d.Ahit", i), 32'(Ahit), 32'(vecs[i].e_hit));
      checkOutput($sformatf("vec%0d.Afwd", i), Afwd, vecs[i].e_fwd);
      checkOutput($sformatf("vec%0d.Bhit", i), 32'(Bhit), 32'(vecs[i].e_hit));
      checkOutput($sformatf("vec%0d.Bfwd", i), Bfwd, vecs[i].e_fwd);
      advance();
    end

    $display("[TB] duplicate register while stalled");
    applyStimulus(1'b0, 1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 5'd0);
    modelCheck("dup0");
    advance();
    applyStimulus(1'b0, 1'b1, 5'd7, 32'hB, 1'b1, 5'd7, 5'd0);
    modelCheck("dup1");
    advance();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);
    modelCheck("dup2");
    checkOutput("dup.Afwd", Afwd, 32'hB);
`ifdef WBQ_COALESCE_EN
    checkOutput("dup.count", 32'(count), 32'd1);
`else
    checkOutput("dup.count", 32'(count), 32'd2);
`endif
    advance();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);
    modelCheck("dup3");
    advance();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);
    modelCheck("dup4");
    checkOutput("dup.first_rw", 32'(RegWrite), 32'h1);
`ifdef WBQ_COALESCE_EN
    checkOutput("dup.first_dat", Wdat, 32'hB);
`else
    checkOutput("dup.first_dat", Wdat, 32'hA);
`endif
    advance();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    modelCheck("dup5");
`ifdef WBQ_COALESCE_EN
    checkOutput("dup.second_rw", 32'(RegWrite), 32'h0);
`else
    checkOutput("dup.second_rw", 32'(RegWrite), 32'h1);
    checkOutput("dup.second_dat", Wdat, 32'hB);
`endif
    advance();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    checkOutput("dup.idle_rw", 32'(RegWrite), 32'h0);
    advance();

    $display("[TB] full queue, pop with rejected push, wrap-around");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(10 + i), 32'hA0 + 32'(i), 1'b1, 5'(10 + i), 5'd10);
      modelCheck("fill");
      advance();
    end
    applyStimulus(1'b0, 1'b1, 5'd14, 32'hEE, 1'b0, 5'd14, 5'd13);
    checkOutput("full.in_ready", 32'(in_ready), 32'h0);
    checkOutput("full.count", 32'(count), 32'd4);
    checkOutput("full.Ahit14", 32'(Ahit), 32'h0);
    advance();
    sb.delete();
    for (int i = 0; i < 4; i++) sb.push_back(32'hA0 + 32'(i));
    nwr = 0;
    for (int i = 0; i < 3 * DEPTH + 6; i++) begin
      if (i < 3 * DEPTH)
        applyStimulus(1'b0, 1'b1, 5'((i % 30) + 1), 32'hC00 + 32'(i), 1'b0,
                      5'($urandom_range(0, 15)), 5'd14);
      else
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd14);
      modelCheck("wrap");
      if (i == 0) begin
        checkOutput("wrap.count_after_full", 32'(count), 32'd3);
        checkOutput("wrap.ready_after_full", 32'(in_ready), 32'h1);
      end
      if (RegWrite === 1'b1) begin
        nwr++;
        if (sb.size() != 0) checkOutput("wrap.order", Wdat, sb.pop_front());
        else checkOutput("wrap.extra_write", Wdat, 32'hFFFFFFFF);
      end
      if (in_valid && mq.size() != DEPTH) sb.push_back(in_dat);
      advance();
    end
    checkOutput("wrap.writes", 32'(nwr), 32'd16);
    checkOutput("wrap.left", 32'(sb.size()), 32'd0);

    $display("[TB] reset with entries pending");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(20 + i), 32'h200 + 32'(i), 1'b1, 5'd20, 5'd21);
      advance();
    end
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd20, 5'd21);
    modelCheck("midrst");
    checkOutput("midrst.in_ready", 32'(in_ready), 32'h0);
    checkOutput("midrst.Ahit", 32'(Ahit), 32'h0);
    advance();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd20, 5'd22);
      modelCheck("postrst");
      checkOutput("postrst.RegWrite", 32'(RegWrite), 32'h0);
      checkOutput("postrst.count", 32'(count), 32'h0);
      checkOutput("postrst.Wdat", Wdat, 32'h0);
      checkOutput("postrst.regW", 32'(regW), 32'h0);
      advance();
    end

    $display("[TB] randomized run against model");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 3) != 0),
                    5'($urandom_range(0, 7)),
                    $urandom(),
                    ($urandom_range(0, 3) == 0),
                    5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)));
      modelCheck("rand");
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
